alu_muldiv: RTL

- Iterative RV32M multiply/divide unit on the Otter datapath, directly downstream of the ALU operand muxes.
- Consumes the selected srcA/srcB operands alongside the single-cycle ALU.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Uses a start/busy/done handshake so the control unit stalls the pipeline until the result is ready.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/alu_muldiv.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// sharing one 64-bit accumulator, with a start/busy/done handshake.
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER) + 1;

  state_e              state_r;
  funct3_e             op_r;
  logic                sign_a_r;
  logic                sign_b_r;
  logic [XLEN-1:0]     mag_a_r;
  logic [XLEN-1:0]     mag_b_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [CW-1:0]       cnt_r;
  logic                special_r;
  logic [XLEN-1:0]     special_val_r;
  logic                busy_r;
  logic                done_r;
  logic [XLEN-1:0]     result_r;

  logic                a_signed_s;
  logic                b_signed_s;
  logic                sign_a_s;
  logic                sign_b_s;
  logic [XLEN-1:0]     mag_a_s;
  logic [XLEN-1:0]     mag_b_s;
  logic                special_s;
  logic [XLEN-1:0]     special_val_s;
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN:0]       div_trial_s;
  logic [XLEN:0]       div_diff_s;
  logic [2*XLEN-1:0]   step_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s;
  logic [XLEN-1:0]     rem_s;
  logic [XLEN-1:0]     final_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

  // Operand signedness and magnitudes; 0x80000000 negates to itself, which is its magnitude.
  always_comb begin
    a_signed_s = (funct3 != OP_MULHU) && (funct3 != OP_DIVU) && (funct3 != OP_REMU);
    b_signed_s = (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
                 (funct3 == OP_DIV) || (funct3 == OP_REM);
    sign_a_s   = a_signed_s & srcA[XLEN-1];
    sign_b_s   = b_signed_s & srcB[XLEN-1];
    mag_a_s    = sign_a_s ? -srcA : srcA;
    mag_b_s    = sign_b_s ? -srcB : srcB;
  end

  // Division corner cases that bypass the iteration entirely.
  always_comb begin
    special_s     = 1'b0;
    special_val_s = {XLEN{1'b0}};
    if (is_div(funct3)) begin
      if (srcB == {XLEN{1'b0}}) begin
        special_s     = 1'b1;
        special_val_s = funct3[1] ? srcA : {XLEN{1'b1}};
      end else if (((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                   (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == {XLEN{1'b1}})) begin
        special_s     = 1'b1;
        special_val_s = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
        special_s     = 1'b0;
        special_val_s = {XLEN{1'b0}};
      end
    end else begin
      special_s     = 1'b0;
      special_val_s = {XLEN{1'b0}};
    end
  end

  // One iteration step. Multiply keeps the multiplier in the low half and shifts right;
  // divide keeps remainder high / dividend-quotient low and shifts left.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                  (acc_r[0] ? {1'b0, mag_a_r} : {(XLEN+1){1'b0}});
    div_trial_s = acc_r[2*XLEN-1:XLEN-1];
    div_diff_s  = div_trial_s - {1'b0, mag_b_r};
    if (is_div(op_r)) begin
      if (!div_diff_s[XLEN]) begin
        step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        step_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection once iteration is complete.
  always_comb begin
    prod_s  = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
    quo_s   = (sign_a_r ^ sign_b_r) ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
    rem_s   = sign_a_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
    final_s = {XLEN{1'b0}};
    case (op_r)
      OP_MUL:                         final_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   final_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                final_s = quo_s;
      OP_REM, OP_REMU:                final_s = rem_s;
      default:                        final_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= IDLE;
      op_r          <= OP_MUL;
      sign_a_r      <= 1'b0;
      sign_b_r      <= 1'b0;
      mag_a_r       <= {XLEN{1'b0}};
      mag_b_r       <= {XLEN{1'b0}};
      acc_r         <= {(2*XLEN){1'b0}};
      cnt_r         <= {CW{1'b0}};
      special_r     <= 1'b0;
      special_val_r <= {XLEN{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      result_r      <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r       <= CALC;
            busy_r        <= 1'b1;
            op_r          <= funct3_e'(funct3);
            sign_a_r      <= sign_a_s;
            sign_b_r      <= sign_b_s;
            mag_a_r       <= mag_a_s;
            mag_b_r       <= mag_b_s;
            special_r     <= special_s;
            special_val_r <= special_val_s;
            if (special_s) begin
              // Counter pre-set to the end so FIN follows on the next edge.
              acc_r <= {(2*XLEN){1'b0}};
              cnt_r <= CW'(ITER);
            end else begin
              acc_r <= is_div(funct3) ? {{XLEN{1'b0}}, mag_a_s} : {{XLEN{1'b0}}, mag_b_s};
              cnt_r <= {CW{1'b0}};
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        CALC: begin
          if (cnt_r < CW'(ITER)) begin
            acc_r <= step_s;
            cnt_r <= cnt_r + CW'(1);
          end else begin
            state_r  <= FIN;
            done_r   <= 1'b1;
            result_r <= special_r ? special_val_r : final_s;
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
